tx_ds_link: RTL and testbench

- Parametrised successor to the single-width D/S character serializer.
- Accepts normal characters (DATA_BITS wide) and link-control characters (LCHAR_BITS wide), frames them with a parity bit and a control flag, and serialises LSB-first.
- Drives the Data/Strobe line pair directly; bit period is programmable at run time.
- Double-buffered: characters stream back-to-back with no idle bit. Sits between the link-layer FSM and the LVDS output pads.

---
 rtl/tx_ds_pkg.sv | 28 ++
 rtl/tx_ds_bitclk.sv | 41 ++++
 rtl/tx_ds_link.sv | 196 +++++++++++++++++++
 tb/tb_tx_ds_link.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tx_ds_pkg.sv
// Shared lchar codes and shifter state encoding for the D/S link transmitter.
// Defining TX_DS_NULL_FILL_EN adds the NULL_ESC/NULL_FCT fill states.
package tx_ds_pkg;

  localparam logic [1:0] LCH_FCT = 2'd0;
  localparam logic [1:0] LCH_EOP = 2'd1;
  localparam logic [1:0] LCH_EEP = 2'd2;
  localparam logic [1:0] LCH_ESC = 2'd3;

`ifdef TX_DS_NULL_FILL_EN
  typedef enum logic [2:0] {
    IDLE,
    PARITY,
    FLAG,
    PAYLOAD,
    NULL_ESC,
    NULL_FCT
  } tx_state_e;
`else
  typedef enum logic [1:0] {
    IDLE,
    PARITY,
    FLAG,
    PAYLOAD
  } tx_state_e;
`endif

endpackage

// File: rtl/tx_ds_bitclk.sv
// Bit-period divider: counts 0..rate and pulses bit_tick on the last count.
// The rate is captured on load so a running character keeps its timing.
module tx_ds_bitclk
  import tx_ds_pkg::*;
#(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [DIV_W-1:0] rate,
  output logic             bit_tick
);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] rate_q, rate_d;

  assign bit_tick = (cnt_q == rate_q);

  always_comb begin
    rate_d = rate_q;
    cnt_d  = cnt_q + 1'b1;
    if (load) begin
      rate_d = rate;
      cnt_d  = '0;
    end else if (bit_tick) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      rate_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      rate_q <= rate_d;
    end
  end

endmodule

// File: rtl/tx_ds_link.sv
// Double-buffered D/S character transmitter: frames P,F,payload LSB-first with odd parity.
// Optional macro TX_DS_NULL_FILL_EN: idle time is filled with NULL (ESC then FCT).
module tx_ds_link
  import tx_ds_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int LCHAR_BITS = 2,
  parameter int DIV_W      = 8
) (
  input  logic                 TxClk,
  input  logic                 TxReset_n,
  input  logic                 valid_i,
  input  logic                 lchar_i,
  input  logic [DATA_BITS-1:0] dat_i,
  input  logic [DIV_W-1:0]     rate_i,
  output logic                 ready_o,
  output logic                 D_o,
  output logic                 S_o,
  output logic                 busy_o
);

  localparam int FRAME_W = DATA_BITS + 2;
  localparam int CNT_W   = $clog2(FRAME_W + 1);
  localparam logic [CNT_W-1:0]     LEFT_N   = CNT_W'(DATA_BITS + 1);
  localparam logic [CNT_W-1:0]     LEFT_L   = CNT_W'(LCHAR_BITS + 1);
  localparam logic [DATA_BITS-1:0] LCH_MASK = DATA_BITS'((64'd1 << LCHAR_BITS) - 64'd1);

  tx_state_e            state_q, state_d;
  logic                 hold_full_q, hold_full_d;
  logic                 hold_lchar_q, hold_lchar_d;
  logic [DATA_BITS-1:0] hold_dat_q, hold_dat_d;
  logic [FRAME_W-1:0]   frame_q, frame_d;
  logic [CNT_W-1:0]     left_q, left_d;
  logic                 d_q, d_d;
  logic                 s_q, s_d;
  logic                 par_q, par_d;
  logic                 rst_done_q, rst_done_d;

  logic                 accept;
  logic                 load_hold, load_esc, load_fct, load_any;
  logic                 shift;
  logic                 bit_tick;
  logic                 src_lchar;
  logic [DATA_BITS-1:0] src_payload;
  logic                 new_bit, drive;

  assign ready_o  = TxReset_n & rst_done_q & ~hold_full_q;
  assign accept   = valid_i & ready_o;
  assign load_any = load_hold | load_esc | load_fct;
  assign busy_o   = (state_q != IDLE);
  assign D_o      = d_q;
  assign S_o      = s_q;

  tx_ds_bitclk #(
    .DIV_W(DIV_W)
  ) u_bitclk (
    .clk     (TxClk),
    .rst_n   (TxReset_n),
    .load    (load_any),
    .rate    (rate_i),
    .bit_tick(bit_tick)
  );

  always_ff @(posedge TxClk) begin
    if (!TxReset_n) begin
      state_q      <= IDLE;
      hold_full_q  <= 1'b0;
      hold_lchar_q <= 1'b0;
      hold_dat_q   <= '0;
      frame_q      <= '0;
      left_q       <= '0;
      d_q          <= 1'b0;
      s_q          <= 1'b0;
      par_q        <= 1'b0;
      rst_done_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      hold_full_q  <= hold_full_d;
      hold_lchar_q <= hold_lchar_d;
      hold_dat_q   <= hold_dat_d;
      frame_q      <= frame_d;
      left_q       <= left_d;
      d_q          <= d_d;
      s_q          <= s_d;
      par_q        <= par_d;
      rst_done_q   <= rst_done_d;
    end
  end

  // A finished frame chains straight into the holding register so there is no gap bit.
  always_comb begin
    state_d   = state_q;
    load_hold = 1'b0;
    load_esc  = 1'b0;
    load_fct  = 1'b0;
    shift     = 1'b0;
    case (state_q)
      IDLE: begin
        if (hold_full_q) begin
          load_hold = 1'b1;
          state_d   = PARITY;
        end
`ifdef TX_DS_NULL_FILL_EN
        else if (rst_done_q) begin
          load_esc = 1'b1;
          state_d  = NULL_ESC;
        end
`endif
      end
      default: begin
        if (bit_tick) begin
          if (left_q != '0) begin
            shift = 1'b1;
            if (state_q == PARITY) begin
              state_d = FLAG;
            end else if (state_q == FLAG) begin
              state_d = PAYLOAD;
            end
          end else begin
`ifdef TX_DS_NULL_FILL_EN
            if (state_q == NULL_ESC) begin
              load_fct = 1'b1;
              state_d  = NULL_FCT;
            end else if (hold_full_q) begin
              load_hold = 1'b1;
              state_d   = PARITY;
            end else begin
              load_esc = 1'b1;
              state_d  = NULL_ESC;
            end
`else
            if (hold_full_q) begin
              load_hold = 1'b1;
              state_d   = PARITY;
            end else begin
              state_d = IDLE;
            end
`endif
          end
        end
      end
    endcase
  end

  always_comb begin
    hold_full_d  = hold_full_q;
    hold_lchar_d = hold_lchar_q;
    hold_dat_d   = hold_dat_q;
    rst_done_d   = 1'b1;
    if (load_hold) begin
      hold_full_d = 1'b0;
    end
    if (accept) begin
      hold_full_d  = 1'b1;
      hold_lchar_d = lchar_i;
      hold_dat_d   = lchar_i ? (dat_i & LCH_MASK) : dat_i;
    end

    src_lchar   = hold_lchar_q;
    src_payload = hold_dat_q;
    if (load_esc) begin
      src_lchar   = 1'b1;
      src_payload = DATA_BITS'(LCH_ESC);
    end
    if (load_fct) begin
      src_lchar   = 1'b1;
      src_payload = DATA_BITS'(LCH_FCT);
    end

    frame_d = frame_q;
    left_d  = left_q;
    par_d   = par_q;
    d_d     = d_q;
    s_d     = s_q;
    new_bit = d_q;
    drive   = 1'b0;
    // On load the parity bit goes straight to the line; F and payload wait in frame_q.
    if (load_any) begin
      frame_d = {1'b0, src_payload, src_lchar};
      left_d  = src_lchar ? LEFT_L : LEFT_N;
      par_d   = ^src_payload;
      new_bit = ~(par_q ^ src_lchar);
      drive   = 1'b1;
    end else if (shift) begin
      frame_d = frame_q >> 1;
      left_d  = left_q - 1'b1;
      new_bit = frame_q[0];
      drive   = 1'b1;
    end
    if (drive) begin
      d_d = new_bit;
      s_d = (new_bit == d_q) ? ~s_q : s_q;
    end
  end

endmodule

// File: tb/tb_tx_ds_link.sv
// Self-checking bench for tx_ds_link (default build, TX_DS_NULL_FILL_EN undefined).
// Directed frames are checked per cycle from a log; random traffic is decoded from D^S.
module tb_tx_ds_link;

  localparam int LOGN = 4096;

  typedef struct {
    bit b;
    int rate;
    bit last;
  } exp_t;

  logic       TxClk;
  logic       TxReset_n;
  logic       valid_i;
  logic       lchar_i;
  logic [7:0] dat_i;
  logic [7:0] rate_i;
  logic       ready_o;
  logic       D_o;
  logic       S_o;
  logic       busy_o;

  int         total = 0;
  int         bad = 0;
  int         cyc = 0;
  logic [3:0] log_v [LOGN];

  bit         model_par = 1'b0;
  bit         model_d = 1'b0;
  bit         model_s = 1'b0;

  exp_t       exp_q [$];
  bit         mon_en = 1'b0;
  bit         mon_last_x = 1'b0;
  bit         have_prev = 1'b0;
  int         prev_start = 0;
  int         prev_need = 0;
  bit         prev_last = 1'b0;

  tx_ds_link #(
    .DATA_BITS (8),
    .LCHAR_BITS(2),
    .DIV_W     (8)
  ) dut (
    .TxClk    (TxClk),
    .TxReset_n(TxReset_n),
    .valid_i  (valid_i),
    .lchar_i  (lchar_i),
    .dat_i    (dat_i),
    .rate_i   (rate_i),
    .ready_o  (ready_o),
    .D_o      (D_o),
    .S_o      (S_o),
    .busy_o   (busy_o)
  );

  initial TxClk = 1'b0;
  always #5 TxClk = ~TxClk;

  always @(posedge TxClk) cyc <= cyc + 1;

  always @(negedge TxClk) begin
    if (cyc < LOGN) log_v[cyc] <= {D_o, S_o, ready_o, busy_o};
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic stepCycle();
    @(negedge TxClk);
    #1;
  endtask

  function automatic logic [3:0] logAt(input int c);
    if (c < 0 || c >= LOGN) return 4'bxxxx;
    return log_v[c];
  endfunction

  // Frame from the rules: P = ~(previous payload xor ^ F), then F, then payload LSB-first.
  task automatic modelChar(input bit lch, input logic [7:0] dat, output logic [9:0] bits, output int n);
    int w;
    bit px;
    w = lch ? 2 : 8;
    n = w + 2;
    bits = '0;
    px = 1'b0;
    bits[0] = ~(model_par ^ lch);
    bits[1] = lch;
    for (int i = 0; i < w; i++) begin
      bits[2+i] = dat[i];
      px ^= dat[i];
    end
    model_par = px;
  endtask

  task automatic checkFrame(input string tag, input int start, input bit lch, input logic [7:0] dat, input int rate);
    logic [9:0] bits;
    logic [3:0] v;
    int n;
    modelChar(lch, dat, bits, n);
    for (int j = 0; j < n; j++) begin
      model_s = (bits[j] == model_d) ? ~model_s : model_s;
      model_d = bits[j];
      for (int r = 0; r <= rate; r++) begin
        v = logAt(start + j * (rate + 1) + r);
        checkOutput(tag, v[3:2], {model_d, model_s});
      end
    end
  endtask

  task automatic applyStimulus(input bit lch, input logic [7:0] dat, input logic [7:0] rate, output int acc);
    int n;
    n = 0;
    acc = -1;
    while (ready_o !== 1'b1 && n < 500) begin
      stepCycle();
      n++;
    end
    if (ready_o !== 1'b1) begin
      checkOutput("ready_timeout", ready_o, 1);
    end else begin
      valid_i = 1'b1;
      lchar_i = lch;
      dat_i   = dat;
      rate_i  = rate;
      acc     = cyc + 1;
      stepCycle();
      valid_i = 1'b0;
    end
  endtask

  task automatic waitIdle();
    int n;
    n = 0;
    while (!(busy_o === 1'b0 && ready_o === 1'b1) && n < 2000) begin
      stepCycle();
      n++;
    end
    checkOutput("idle_reached", {busy_o, ready_o}, 2'b01);
    stepCycle();
    stepCycle();
  endtask

  // Random-phase decoder: every D^S change starts a new bit.
  always @(negedge TxClk) begin
    exp_t e;
    int dur;
    if (mon_en && ((D_o ^ S_o) != mon_last_x)) begin
      if (have_prev) begin
        dur = cyc - prev_start;
        if (prev_last) checkOutput("rnd_tail", (dur >= prev_need), 1);
        else checkOutput("rnd_dur", dur, prev_need);
      end
      if (exp_q.size() == 0) begin
        checkOutput("rnd_extra_bit", exp_q.size(), 1);
      end else begin
        e = exp_q.pop_front();
        checkOutput("rnd_bit", D_o, e.b);
        prev_need  = e.rate + 1;
        prev_last  = e.last;
        prev_start = cyc;
        have_prev  = 1'b1;
      end
      mon_last_x = D_o ^ S_o;
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int a, b;
    logic [3:0] v;
    logic [9:0] bits;
    int n;
    exp_t e;

    TxReset_n = 1'b0;
    valid_i   = 1'b0;
    lchar_i   = 1'b0;
    dat_i     = '0;
    rate_i    = '0;
    repeat (3) stepCycle();
    checkOutput("rst_state", {D_o, S_o, ready_o, busy_o}, 4'b0000);

    TxReset_n = 1'b1;
    stepCycle();
    for (int i = 0; i < 20; i++) begin
      checkOutput("idle_after_rst", {D_o, S_o, ready_o, busy_o}, 4'b0010);
      stepCycle();
    end

    $display("[TB] normal 0xAA at rate 0");
    applyStimulus(1'b0, 8'hAA, 8'd0, a);
    repeat (16) stepCycle();
    v = logAt(a);
    checkOutput("aa_ready_fall", v[1], 0);
    v = logAt(a + 1);
    checkOutput("aa_ready_back", v[1], 1);
    checkOutput("aa_first_parity", v[3], 1);
    checkFrame("aa_frame", a + 1, 1'b0, 8'hAA, 0);
    v = logAt(a + 10);
    checkOutput("aa_busy_last", v[0], 1);
    v = logAt(a + 11);
    checkOutput("aa_busy_end", v[0], 0);
    for (int i = 11; i <= 15; i++) begin
      v = logAt(a + i);
      checkOutput("aa_hold_lines", v[3:2], 2'b11);
    end

    $display("[TB] back-to-back lchars");
    applyStimulus(1'b1, 8'h02, 8'd0, a);
    applyStimulus(1'b1, 8'h00, 8'd0, b);
    repeat (12) stepCycle();
    checkOutput("b2b_accept2", b, a + 2);
    checkFrame("b2b_frame1", a + 1, 1'b1, 8'h02, 0);
    checkFrame("b2b_frame2", a + 5, 1'b1, 8'h00, 0);
    v = logAt(a + 4);
    checkOutput("b2b_ready_full", v[1], 0);
    v = logAt(a + 5);
    checkOutput("b2b_ready_back", v[1], 1);
    checkOutput("b2b_no_gap", v[0], 1);
    v = logAt(a + 9);
    checkOutput("b2b_busy_end", v[0], 0);

    $display("[TB] rate 3 with mid-frame rate change");
    waitIdle();
    applyStimulus(1'b0, 8'h55, 8'd3, a);
    for (int i = 1; i <= 44; i++) begin
      stepCycle();
      if (i == 6) rate_i = 8'd0;
    end
    checkFrame("rate3_frame", a + 1, 1'b0, 8'h55, 3);
    v = logAt(a + 40);
    checkOutput("rate3_busy_last", v[0], 1);
    v = logAt(a + 41);
    checkOutput("rate3_busy_end", v[0], 0);
    applyStimulus(1'b0, 8'h0F, 8'd0, b);
    repeat (12) stepCycle();
    checkFrame("rate0_next", b + 1, 1'b0, 8'h0F, 0);

    $display("[TB] reset during D3");
    waitIdle();
    applyStimulus(1'b0, 8'hAA, 8'd0, a);
    repeat (6) stepCycle();
    v = logAt(a + 6);
    checkOutput("pre_rst_d3", v[3], 1);
    TxReset_n = 1'b0;
    stepCycle();
    stepCycle();
    TxReset_n = 1'b1;
    repeat (3) stepCycle();
    for (int i = 7; i <= 8; i++) begin
      v = logAt(a + i);
      checkOutput("mid_rst_state", v, 4'b0000);
    end
    for (int i = 9; i <= 11; i++) begin
      v = logAt(a + i);
      checkOutput("post_rst_state", v, 4'b0010);
    end
    model_par = 1'b0;
    model_d   = 1'b0;
    model_s   = 1'b0;
    applyStimulus(1'b1, 8'h01, 8'd0, b);
    repeat (8) stepCycle();
    v = logAt(b + 1);
    checkOutput("post_rst_parity", v[3], 0);
    checkFrame("post_rst_frame", b + 1, 1'b1, 8'h01, 0);

    $display("[TB] random traffic");
    waitIdle();
    exp_q.delete();
    have_prev  = 1'b0;
    mon_last_x = D_o ^ S_o;
    mon_en     = 1'b1;
    for (int k = 0; k < 40; k++) begin
      bit lch;
      logic [7:0] dat;
      logic [7:0] rate;
      repeat ($urandom_range(0, 3)) stepCycle();
      lch  = ($urandom_range(0, 3) == 0);
      dat  = 8'($urandom);
      rate = 8'($urandom_range(0, 3));
      modelChar(lch, dat, bits, n);
      for (int j = 0; j < n; j++) begin
        e.b    = bits[j];
        e.rate = int'(rate);
        e.last = (j == n - 1);
        exp_q.push_back(e);
      end
      applyStimulus(lch, dat, rate, a);
    end
    waitIdle();
    repeat (4) stepCycle();
    mon_en = 1'b0;
    checkOutput("rnd_all_bits_seen", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
